// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch request/response bundle between IFU and instruction memory
interface imem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - single-outstanding instruction fetch responder with fixed latency and preload port
module imem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   localparam int         AW          = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   imem_responder_if.slave       bus,
   input  logic                  ld_en_i,
   input  logic [AW-1:0]         ld_addr_i,
   input  logic [31:0]           ld_data_i
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        resp_err_q, resp_err_d;
   logic        capture;
   logic [31:0] cap_addr;
   logic [31:0] off;
   logic        cap_err;

   logic [31:0] mem_q [DEPTH_WORDS];

   // Preload is independent of reset so the image can be loaded while the core is held.
   always_ff @(posedge clk_i) begin
      if (ld_en_i) begin
         mem_q[ld_addr_i] <= ld_data_i;
      end
   end

   // With LATENCY=1 the capture happens on the acceptance edge, straight from the bus.
   assign cap_addr = (state_q == S_IDLE) ? bus.req_addr : addr_q;
   assign off      = cap_addr - BASE_ADDR;
   assign cap_err  = (cap_addr[1:0] != 2'b00) || ({1'b0, off} >= SPAN);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      capture     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               addr_d = bus.req_addr;
               cnt_d  = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  state_d = S_RESP;
                  capture = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
               capture = 1'b1;
            end
            cnt_d = cnt_q - 4'd1;
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      if (capture) begin
         resp_err_d  = cap_err;
         resp_data_d = cap_err ? 32'h0 : mem_q[off[AW+1:2]];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= 32'h0;
         resp_data_q <= 32'h0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // Gating with rst_ni keeps req_ready low during reset while state already reads IDLE.
   assign bus.req_ready  = (state_q == S_IDLE) && rst_ni;
   assign bus.resp_valid = (state_q == S_RESP);
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the slave end of the fetch interface driven by the instruction-fetch unit. It accepts one fetch request at a time, waits a programmable number of cycles, and returns the addressed 32-bit word with a valid/ready handshake. Misaligned and out-of-range fetches return an error flag. A side-band load port lets the simulation harness preload the program image. The block sits between the IFU's fetch request path and the core's instruction bus model in the NPC.

## Interface
Parameters:
- DEPTH_WORDS, 1024: memory depth in 32-bit words; power of two, ≥ 2.
- LATENCY, 2: cycles from request acceptance to first `resp_valid`; range 1..15.
- BASE_ADDR, 32'h8000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  fetch byte address.
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  fetched instruction word.
- resp_err  out  1  1 = misaligned or out-of-range fetch.
- ld_en  in  1  preload write enable.
- ld_addr  in  log2(DEPTH_WORDS)  preload word index.
- ld_data  in  32  preload data.

## Operation
- Three states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, the request is accepted: latch `req_addr`, compute error, load the countdown with LATENCY-1.
  - Next state is RESP if LATENCY=1, else WAIT.
- WAIT:
  - `req_ready` = 0.
  - Decrement the countdown each cycle; when it reaches 0, go to RESP.
- Entering RESP:
  - Capture `resp_data` and `resp_err` into registers.
  - `resp_err` = 1 if addr[1:0] ≠ 0, or if (addr − BASE_ADDR) ≥ DEPTH_WORDS*4. The subtraction is unsigned 32-bit, so addresses below BASE wrap large and count as out of range.
  - On error, `resp_data` = 0. Otherwise `resp_data` = mem[(addr − BASE_ADDR) >> 2].
- RESP:
  - `resp_valid` = 1 and `req_ready` = 0.
  - `resp_data` and `resp_err` are held stable until `resp_valid && resp_ready`.
  - On that handshake, go to IDLE; `resp_valid` drops the following cycle.
- Exactly one request is outstanding at a time. Requests presented outside IDLE are ignored and must be held by the initiator.
- Load port:
  - `ld_en` writes mem[ld_addr] = ld_data on the clock edge. It is legal in any state, including during reset.
  - Read-before-write: a capture on the same edge as a write to the same word returns the old value.
  - After capture, later writes do not alter the held response.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - state = IDLE; `resp_valid` = 0, `resp_data` = 0, `resp_err` = 0.
  - `req_ready` = 0 while `rst` = 0. It is 1 in the first cycle after deassertion.
- Request latency: a request accepted at edge T gives `resp_valid` = 1 after edge T+LATENCY.
- Best-case throughput: one response per LATENCY+1 cycles, with `resp_ready` tied to 1.
- Back-pressure: `resp_valid` stays high indefinitely while `resp_ready` = 0. There is no timeout.
- Reset asserted mid-operation (WAIT or RESP): the in-flight request is immediately discarded and all outputs take their reset values asynchronously. No response is produced after release.
- `resp_ready` high outside RESP has no effect.

## Test plan
- Basic fetch:
  - Stimulus: LATENCY=2; preload word 0 = 32'h0000_0413 and word 1 = 32'h0010_0073. Request 32'h8000_0000 at cycle 0, `resp_ready` = 1.
  - Required: `resp_valid` in cycle 2 with data 32'h0000_0413 and err 0; `req_ready` = 1 again in cycle 3. A request to 32'h8000_0004 then returns 32'h0010_0073.
- Back-pressure:
  - Stimulus: hold `resp_ready` = 0 for 5 cycles after `resp_valid` rises, while `ld_en` overwrites the same word with 32'hDEAD_BEEF.
  - Required: `resp_data` stays at the old value throughout; `req_ready` stays 0; handshake completes on the first cycle `resp_ready` = 1.
- Errors:
  - Stimulus: request 32'h8000_0002; then 32'h8000_1000 with DEPTH_WORDS=1024; then 32'h7FFF_FFFC.
  - Required: each returns err = 1 and data = 0 after LATENCY cycles.
- Latency sweep:
  - Stimulus: LATENCY = 1, 3, 15 with `resp_ready` = 1.
  - Required: valid exactly LATENCY cycles after acceptance; spacing between acceptances is LATENCY+1.
- Reset mid-operation:
  - Stimulus: assert `rst` = 0 one cycle after acceptance; release 3 cycles later.
  - Required: `resp_valid` = 0 immediately and no stale response after release; preloaded memory is intact on the next fetch.
- Ignored request:
  - Stimulus: pulse `req_valid` with another address during WAIT, then drop it.
  - Required: only the first request gets a response.
